video_stream_padder: RTL and testbench
======================================

VIDEO_STREAM_PADDER -- requirements
Module: video_stream_padder

Interface
REQ-001 Parameter DATA_W, default 8: data word width in bits.
REQ-002 Parameter ALIGN, default 16: output words are padded to a multiple of ALIGN; ALIGN >= 1.
REQ-003 Parameter PAD_LEN, default 16: number of tail pad words after alignment; PAD_LEN >= 1.
REQ-004 Parameter PAD_MODE, default 0: 0 = pad with PAD_VALUE; 1 = pad with the last data word.
REQ-005 Parameter PAD_VALUE, default 0 (DATA_W bits): constant pad word.
REQ-006 clk  in  1  sole clock; every register updates on its rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 clk_en  in  1  qualifies every state/counter update and every input write.
REQ-009 stream_end  in  1  end-of-stream indication, sampled when clk_en=1.
REQ-010 restart  in  1  returns the block to IDLE from any state.
REQ-011 vbuf_in  in  DATA_W  upstream data word.
REQ-012 vbuf_wr_in  in  1  upstream write strobe.
REQ-013 vbuf_out  out  DATA_W  downstream data word.
REQ-014 vbuf_wr_out  out  1  downstream write strobe.
REQ-015 pad_active  out  1  high in ALIGN or TAIL.
REQ-016 done  out  1  high in FINISH.
REQ-017 drop_err  out  1  sticky flag: an upstream write was discarded.

Function
REQ-018 The FSM SHALL have the states IDLE, ALIGN, TAIL and FINISH; it advances only on cycles with clk_en=1.
REQ-019 IDLE: vbuf_out=vbuf_in and vbuf_wr_out=vbuf_wr_in, combinationally (zero latency).
REQ-020 IDLE: each clk_en & vbuf_wr_in cycle increments align_cnt modulo ALIGN and, when PAD_MODE=1, captures vbuf_in into last_word.
REQ-021 IDLE & clk_en & stream_end: next state is TAIL if align_cnt after this cycle's increment is 0, else ALIGN.
REQ-022 A write coincident with stream_end is forwarded and counted before padding begins.
REQ-023 ALIGN/TAIL: vbuf_wr_out = clk_en, and vbuf_out = pad word; exactly one pad word per enabled cycle.
REQ-024 ALIGN: each pad word increments align_cnt; when align_cnt = ALIGN-1 on an enabled cycle, go to TAIL.
REQ-025 TAIL: tail_cnt counts 0..PAD_LEN-1; on an enabled cycle with tail_cnt = PAD_LEN-1, go to FINISH.
REQ-026 FINISH: vbuf_wr_out=0; done=1; the block stays in FINISH until restart.
REQ-027 In ALIGN/TAIL/FINISH, vbuf_wr_in is not forwarded; clk_en & vbuf_wr_in sets drop_err.
REQ-028 stream_end outside IDLE is ignored.
REQ-029 restart & clk_en: next state is IDLE, and align_cnt, tail_cnt, drop_err clear; restart has priority over stream_end and any count terminal condition.
REQ-030 ALIGN=1 never enters ALIGN; PAD_MODE=1 with no prior write pads with PAD_VALUE.
REQ-031 Counter widths: align_cnt is $clog2(ALIGN) bits (minimum 1); tail_cnt is $clog2(PAD_LEN) bits (minimum 1); both wrap explicitly at their terminal value.

Reset
REQ-032 When rst=1, asynchronously: state=IDLE, align_cnt=0, tail_cnt=0, last_word=PAD_VALUE, drop_err=0.
REQ-033 Output reset values follow: pad_active=0, done=0, vbuf_out=vbuf_in, vbuf_wr_out=vbuf_wr_in.
REQ-034 Reset asserted mid-padding aborts the padding immediately, with no further pad words.

Structure
REQ-035 The state encodings (2-bit) and PAD_MODE constants SHALL live in shared package video_pkg.
REQ-036 align_cnt and tail_cnt SHALL each be an instance of one sub-module, mod_counter (parameters MOD; ports clk, rst, clr, inc, count, last).

Verification (ALIGN=4, PAD_LEN=3, PAD_VALUE=8'h00 unless stated; clk_en=1)
REQ-037 Write 5 words, stream_end on the 5th -> 3 ALIGN words + 3 TAIL words of 8'h00, then done=1; 11 strobes out in total.
REQ-038 Write 8 words, stream_end on the 8th -> ALIGN skipped, exactly 3 pad words, then done=1.
REQ-039 PAD_MODE=1, last word 8'hA5, 2 words written -> 2 + 3 pad words, all 8'hA5.
REQ-040 clk_en toggling 1,0 during TAIL -> vbuf_wr_out only on enabled cycles; pad count is still 3.
REQ-041 vbuf_wr_in during ALIGN -> not forwarded, drop_err=1; restart in FINISH -> IDLE, drop_err=0, passthrough resumes.
REQ-042 rst asserted after 1 TAIL word -> vbuf_wr_out follows vbuf_wr_in in the same cycle; no further pad words; done=0.

Source files
------------

// File: rtl/video_pkg.sv
// Shared definitions for the video stream padder.
//   state_t      : 2-bit padder FSM state encoding
//   PAD_MODE_*   : pad word source selection values
//   cnt_width()  : bit width of a modulo-N counter (never below 1)
package video_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_TAIL   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam int PAD_MODE_CONST = 0;  // pad with PAD_VALUE
  localparam int PAD_MODE_LAST  = 1;  // pad with the last data word

  function automatic int cnt_width(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/video_stream_padder_if.sv
// Data word bus between upstream producer, padder and downstream consumer.
//   vbuf_in/vbuf_wr_in   : upstream word and write strobe
//   vbuf_out/vbuf_wr_out : downstream word and write strobe
// master = test/driver side, slave = padder side.
interface video_stream_padder_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] vbuf_in;
  logic              vbuf_wr_in;
  logic [DATA_W-1:0] vbuf_out;
  logic              vbuf_wr_out;

  modport master (
    output vbuf_in, vbuf_wr_in,
    input  vbuf_out, vbuf_wr_out
  );

  modport slave (
    input  vbuf_in, vbuf_wr_in,
    output vbuf_out, vbuf_wr_out
  );
endinterface

// File: rtl/video_stream_padder_counter.sv
// Modulo-MOD counter with synchronous clear.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (wins over inc)
//   inc      : advance by one, wrapping from MOD-1 to 0
//   count    : current value
//   last     : count is at its terminal value MOD-1
module mod_counter
  import video_pkg::*;
#(
  parameter int MOD = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      inc,
  output logic [cnt_width(MOD)-1:0] count,
  output logic                      last
);
  localparam int W = cnt_width(MOD);

  assign last = (count == W'(MOD - 1));

  // Count register: clear has priority, explicit wrap at the terminal value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= {W{1'b0}};
    end else if (clr) begin
      count <= {W{1'b0}};
    end else if (inc) begin
      count <= last ? {W{1'b0}} : count + W'(1'b1);
    end else begin
      count <= count;
    end
  end
endmodule

// File: rtl/video_stream_padder.sv
// Video stream padder: passes words through until stream_end, then pads the
// stream to a multiple of ALIGN words and appends PAD_LEN tail pad words.
//   clk, rst     : clock, asynchronous active-high reset
//   clk_en       : qualifies all state updates and input writes
//   stream_end   : end of stream (acted on only in IDLE)
//   restart      : return to IDLE and clear counters / drop_err
//   vbuf         : upstream/downstream word bus (slave side)
//   pad_active   : padding in progress (ALIGN or TAIL)
//   done         : padding complete (FINISH)
//   drop_err     : sticky, an upstream write arrived while not in IDLE
module video_stream_padder
  import video_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                ALIGN     = 16,
  parameter int                PAD_LEN   = 16,
  parameter int                PAD_MODE  = 0,
  parameter logic [DATA_W-1:0] PAD_VALUE = {DATA_W{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  stream_end,
  input  logic                  restart,
  video_stream_padder_if.slave  vbuf,
  output logic                  pad_active,
  output logic                  done,
  output logic                  drop_err
);
  localparam int AW = cnt_width(ALIGN);

  state_t            state;
  state_t            next_state;
  logic              cnt_clr;
  logic              align_inc;
  logic              tail_inc;
  logic [AW-1:0]     align_count;
  logic              align_last;
  logic              tail_last;
  logic [DATA_W-1:0] last_word;
  logic [DATA_W-1:0] pad_word;

  assign cnt_clr = clk_en & restart;

  mod_counter #(.MOD(ALIGN)) u_align_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (align_inc),
    .count (align_count),
    .last  (align_last)
  );

  mod_counter #(.MOD(PAD_LEN)) u_tail_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (tail_inc),
    .count (),
    .last  (tail_last)
  );

  // Next-state and counter-advance decode; restart overrides everything.
  always_comb begin
    next_state = state;
    align_inc  = 1'b0;
    tail_inc   = 1'b0;
    if (clk_en && restart) begin
      next_state = ST_IDLE;
    end else if (clk_en) begin
      case (state)
        ST_IDLE: begin
          align_inc = vbuf.vbuf_wr_in;
          if (stream_end) begin
            // Aligned after this cycle's write: counter wraps (write on last)
            // or stays at zero (no write).
            if (vbuf.vbuf_wr_in ? align_last : (align_count == {AW{1'b0}})) begin
              next_state = ST_TAIL;
            end else begin
              next_state = ST_ALIGN;
            end
          end else begin
            next_state = ST_IDLE;
          end
        end
        ST_ALIGN: begin
          align_inc = 1'b1;
          if (align_last) begin
            next_state = ST_TAIL;
          end else begin
            next_state = ST_ALIGN;
          end
        end
        ST_TAIL: begin
          tail_inc = 1'b1;
          if (tail_last) begin
            next_state = ST_FINISH;
          end else begin
            next_state = ST_TAIL;
          end
        end
        ST_FINISH: next_state = ST_FINISH;
        default:   next_state = ST_IDLE;
      endcase
    end else begin
      next_state = state;
    end
  end

  // Output decode: zero-latency passthrough in IDLE, pad words otherwise.
  always_comb begin
    pad_word         = (PAD_MODE == PAD_MODE_LAST) ? last_word : PAD_VALUE;
    vbuf.vbuf_out    = vbuf.vbuf_in;
    vbuf.vbuf_wr_out = vbuf.vbuf_wr_in;
    pad_active       = 1'b0;
    done             = 1'b0;
    case (state)
      ST_IDLE: begin
        vbuf.vbuf_out    = vbuf.vbuf_in;
        vbuf.vbuf_wr_out = vbuf.vbuf_wr_in;
      end
      ST_ALIGN, ST_TAIL: begin
        vbuf.vbuf_out    = pad_word;
        vbuf.vbuf_wr_out = clk_en;
        pad_active       = 1'b1;
      end
      ST_FINISH: begin
        vbuf.vbuf_out    = pad_word;
        vbuf.vbuf_wr_out = 1'b0;
        done             = 1'b1;
      end
      default: begin
        vbuf.vbuf_out    = vbuf.vbuf_in;
        vbuf.vbuf_wr_out = vbuf.vbuf_wr_in;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Last accepted data word; starts at PAD_VALUE so an empty stream pads with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_word <= PAD_VALUE;
    end else if (clk_en && vbuf.vbuf_wr_in && (state == ST_IDLE)
                 && (PAD_MODE == PAD_MODE_LAST)) begin
      last_word <= vbuf.vbuf_in;
    end else begin
      last_word <= last_word;
    end
  end

  // Sticky drop flag: writes outside IDLE are discarded; restart clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_err <= 1'b0;
    end else if (clk_en && restart) begin
      drop_err <= 1'b0;
    end else if (clk_en && vbuf.vbuf_wr_in && (state != ST_IDLE)) begin
      drop_err <= 1'b1;
    end else begin
      drop_err <= drop_err;
    end
  end
endmodule

// File: tb/tb_video_stream_padder.sv
// Directed bench for video_stream_padder (ALIGN=4, PAD_LEN=3, PAD_VALUE=0).
// dut0 pads with a constant, dut1 pads with the last data word; both share
// the same stimulus.
module tb_video_stream_padder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       se = 1'b0;
  logic       rs = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] din = 8'h00;

  logic pad_active0, done0, drop0;
  logic pad_active1, done1, drop1;

  int checks = 0;
  int failures = 0;

  int n0, npad0, padbad0, baden0;
  int n1, npad1, padbad1;
  logic [7:0] exp_pad0, exp_pad1;
  logic [7:0] last_out0;
  logic       last_wr0;

  video_stream_padder_if #(.DATA_W(8)) if0 ();
  video_stream_padder_if #(.DATA_W(8)) if1 ();

  assign if0.vbuf_in    = din;
  assign if0.vbuf_wr_in = wr;
  assign if1.vbuf_in    = din;
  assign if1.vbuf_wr_in = wr;

  always #5 clk = ~clk;

  video_stream_padder #(
    .DATA_W(8), .ALIGN(4), .PAD_LEN(3), .PAD_MODE(0), .PAD_VALUE(8'h00)
  ) dut0 (
    .clk(clk), .rst(rst), .clk_en(en), .stream_end(se), .restart(rs),
    .vbuf(if0), .pad_active(pad_active0), .done(done0), .drop_err(drop0)
  );

  video_stream_padder #(
    .DATA_W(8), .ALIGN(4), .PAD_LEN(3), .PAD_MODE(1), .PAD_VALUE(8'h00)
  ) dut1 (
    .clk(clk), .rst(rst), .clk_en(en), .stream_end(se), .restart(rs),
    .vbuf(if1), .pad_active(pad_active1), .done(done1), .drop_err(drop1)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_tally();
    n0 = 0; npad0 = 0; padbad0 = 0; baden0 = 0;
    n1 = 0; npad1 = 0; padbad1 = 0;
  endtask

  // One cycle: drive inputs after the falling edge, then sample outputs.
  task automatic drive(input logic w, input logic [7:0] d, input logic s,
                       input logic e, input logic r);
    @(negedge clk);
    wr = w; din = d; se = s; en = e; rs = r;
    #1;
    last_out0 = if0.vbuf_out;
    last_wr0  = if0.vbuf_wr_out;
    if (if0.vbuf_wr_out) n0++;
    if (if0.vbuf_wr_out && pad_active0) begin
      npad0++;
      if (if0.vbuf_out !== exp_pad0) padbad0++;
      if (!e) baden0++;
    end
    if (if1.vbuf_wr_out) n1++;
    if (if1.vbuf_wr_out && pad_active1) begin
      npad1++;
      if (if1.vbuf_out !== exp_pad1) padbad1++;
    end
  endtask

  task automatic write_stream(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) drive(1'b1, base + 8'(i), (i == n - 1), 1'b1, 1'b0);
  endtask

  task automatic run_to_done(input bit toggle);
    int k;
    k = 0;
    while (!done0 && k < 20) begin
      drive(1'b0, 8'h00, 1'b0, toggle ? (k % 2 == 0) : 1'b1, 1'b0);
      k++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wr = 1'b0; din = 8'h00; se = 1'b0; en = 1'b0; rs = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    clear_tally();
  endtask

  initial begin
    clear_tally();
    exp_pad0 = 8'h00;
    exp_pad1 = 8'h00;

    // Reset state and passthrough while held in reset
    #1;
    check_val("rst_pad_active", pad_active0, 1'b0);
    check_val("rst_done", done0, 1'b0);
    check_val("rst_drop", drop0, 1'b0);
    wr = 1'b1; din = 8'h5A;
    #1;
    check_val("rst_pass_data", if0.vbuf_out, 8'h5A);
    check_val("rst_pass_wr", if0.vbuf_wr_out, 1'b1);

    // 5 words -> 3 align + 3 tail pads, 11 strobes
    do_reset();
    exp_pad0 = 8'h00; exp_pad1 = 8'h05;
    write_stream(5, 8'h01);
    run_to_done(1'b0);
    check_val("a_total", n0, 11);
    check_val("a_pads", npad0, 6);
    check_val("a_padval", padbad0, 0);
    check_val("a_done", done0, 1'b1);
    check_val("a_pad_active_fin", pad_active0, 1'b0);
    check_val("a_last_pads", npad1, 6);
    check_val("a_last_padval", padbad1, 0);

    // 8 words -> aligned, tail only
    do_reset();
    exp_pad0 = 8'h00; exp_pad1 = 8'h27;
    write_stream(8, 8'h20);
    run_to_done(1'b0);
    check_val("b_total", n0, 11);
    check_val("b_pads", npad0, 3);
    check_val("b_done", done0, 1'b1);

    // Last-word padding: 2 words, last A5
    do_reset();
    exp_pad0 = 8'h00; exp_pad1 = 8'hA5;
    drive(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0);
    run_to_done(1'b0);
    check_val("c_last_pads", npad1, 5);
    check_val("c_last_padval", padbad1, 0);
    check_val("c_last_done", done1, 1'b1);
    check_val("c_const_pads", npad0, 5);

    // clk_en toggling during tail
    do_reset();
    exp_pad0 = 8'h00; exp_pad1 = 8'h47;
    write_stream(8, 8'h40);
    run_to_done(1'b1);
    check_val("d_pads", npad0, 3);
    check_val("d_strobe_no_en", baden0, 0);
    check_val("d_done", done0, 1'b1);

    // Write during ALIGN is dropped; restart clears and resumes passthrough
    do_reset();
    exp_pad0 = 8'h00; exp_pad1 = 8'h10;
    drive(1'b1, 8'h10, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    check_val("e_drop_set", drop0, 1'b1);
    run_to_done(1'b0);
    check_val("e_pads", npad0, 6);
    check_val("e_padval", padbad0, 0);
    check_val("e_done", done0, 1'b1);
    check_val("e_drop_sticky", drop0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    check_val("e_restart_done", done0, 1'b0);
    check_val("e_restart_drop", drop0, 1'b0);
    drive(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0);
    check_val("e_pass_data", last_out0, 8'h3C);
    check_val("e_pass_wr", last_wr0, 1'b1);

    // Reset after one tail word aborts padding
    do_reset();
    exp_pad0 = 8'h00; exp_pad1 = 8'h67;
    write_stream(8, 8'h60);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check_val("f_one_tail", npad0, 1);
    @(negedge clk);
    rst = 1'b1; wr = 1'b1; din = 8'hE1;
    #1;
    check_val("f_rst_wr", if0.vbuf_wr_out, 1'b1);
    check_val("f_rst_data", if0.vbuf_out, 8'hE1);
    check_val("f_rst_pad_active", pad_active0, 1'b0);
    @(negedge clk);
    rst = 1'b0; wr = 1'b0;
    for (int i = 0; i < 5; i++) drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check_val("f_no_more_pads", npad0, 1);
    check_val("f_done", done0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
